pipe_regfile: RTL

PIPE_REGFILE -- requirements
Module: pipe_regfile

---
 rtl/pipe_regfile.sv | 98 +++++++++
 1 files changed

// File: rtl/pipe_regfile.sv
// Writeback-stage register file for a Y86-style pipeline: two write ports with
// M-over-E priority, two bypassed read ports, sticky status and a retire counter.
module pipe_regfile #(
  parameter int                 DATA_W  = 64,
  parameter int                 NREG    = 15,
  parameter int                 SP_IDX  = 4,
  parameter logic [DATA_W-1:0]  SP_INIT = 'h100,
  parameter int                 CNT_W   = 32
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic [2:0]             W_stat,
  input  logic [3:0]             W_icode,
  input  logic                   W_Cnd,
  input  logic [DATA_W-1:0]      W_valE,
  input  logic [DATA_W-1:0]      W_valM,
  input  logic [3:0]             W_dstE,
  input  logic [3:0]             W_dstM,
  input  logic [3:0]             srcA,
  input  logic [3:0]             srcB,
  output logic [DATA_W-1:0]      valA,
  output logic [DATA_W-1:0]      valB,
  output logic [2:0]             stat,
  output logic                   halted,
  output logic [CNT_W-1:0]       retired,
  output logic [NREG*DATA_W-1:0] regs_flat
);

  localparam logic [2:0] STAT_AOK   = 3'h1;
  localparam logic [3:0] ICODE_NOP  = 4'h1;
  localparam logic [3:0] ICODE_CMOV = 4'h2;
  localparam logic [4:0] NREG_W     = 5'(NREG);

  logic [DATA_W-1:0] regs [NREG];
  logic              stage_aok;
  logic              wr_ok;
  logic              we_e;
  logic              we_m;

  assign stage_aok = (W_stat == STAT_AOK);
  assign halted    = (stat != STAT_AOK);

  // Gating on rst keeps the bypass path from exposing a write that reset discards.
  assign wr_ok = stage_aok && !halted && !rst &&
                 !(W_icode == ICODE_CMOV && !W_Cnd);
  assign we_e  = wr_ok && ({1'b0, W_dstE} < NREG_W);
  assign we_m  = wr_ok && ({1'b0, W_dstM} < NREG_W);

  // NOTE: the register array is reset explicitly because software observes the
  // stack pointer's initial value; this keeps it in flops rather than a RAM macro.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < NREG; i++)
        regs[i] <= (i == SP_IDX) ? SP_INIT : '0;
    end else begin
      // NOTE: non-blocking assignments so every flop samples pre-edge values.
      for (int i = 0; i < NREG; i++) begin
        if (we_m && W_dstM == 4'(i))
          regs[i] <= W_valM;
        else if (we_e && W_dstE == 4'(i))
          regs[i] <= W_valE;
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst)
      stat <= STAT_AOK;
    else if (!halted && !stage_aok && W_stat != 3'h0)
      stat <= W_stat;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst)
      retired <= '0;
    else if (!halted && stage_aok && W_icode != ICODE_NOP && retired != '1)
      retired <= retired + 1'b1;
  end

  // NOTE: outputs get a default before any conditional assignment so no latch is inferred.
  always_comb begin
    valA = '0;
    valB = '0;
    for (int i = 0; i < NREG; i++) begin
      if (srcA == 4'(i)) valA = regs[i];
      if (srcB == 4'(i)) valB = regs[i];
    end
    if (we_e && srcA == W_dstE) valA = W_valE;
    if (we_m && srcA == W_dstM) valA = W_valM;
    if (we_e && srcB == W_dstE) valB = W_valE;
    if (we_m && srcB == W_dstM) valB = W_valM;
  end

  for (genvar g = 0; g < NREG; g++) begin : g_flat
    assign regs_flat[g*DATA_W +: DATA_W] = regs[g];
  end

endmodule
